fifo_wr_arb_ctrl: RTL and testbench
===================================

// Module: fifo_wr_arb_ctrl
// PURPOSE
//  Single-clock controller that shares one fifo memory write port between two producers
//  (round-robin) and sequences it as a FIFO: write/read pointers, full/empty/count flags.
//  Drives the memory's wclk_en/w_addr/w_data/r_addr ports, consumes its combinational r_data.
//  Sits between two producer streams and one consumer in the same clock domain.
// PARAMETERS
//  DATA_WIDTH  8   width of a FIFO word
//  ADDR_WIDTH  4   memory address width; depth = 2**ADDR_WIDTH
//  AFULL_THR   12  almost_full asserts when count >= AFULL_THR (1..2**ADDR_WIDTH)
// PORTS
//  clk          in   1             single clock, rising edge
//  rst          in   1             synchronous reset, active-high
//  flush        in   1             synchronous clear of FIFO contents (pointers only)
//  s0_valid     in   1             producer 0 has a word
//  s0_data      in   DATA_WIDTH    producer 0 word
//  s0_ready     out  1             producer 0 word accepted this cycle (grant)
//  s1_valid     in   1             producer 1 has a word
//  s1_data      in   DATA_WIDTH    producer 1 word
//  s1_ready     out  1             producer 1 word accepted this cycle (grant)
//  m_valid      out  1             head word available (= !empty)
//  m_data       out  DATA_WIDTH    head word (= mem_r_data)
//  m_ready      in   1             consumer pops head when m_valid & m_ready
//  mem_wclk_en  out  1             memory write enable
//  mem_w_addr   out  ADDR_WIDTH    memory write address
//  mem_w_data   out  DATA_WIDTH    memory write data
//  mem_r_addr   out  ADDR_WIDTH    memory read address
//  mem_r_data   in   DATA_WIDTH    memory read data (combinational from mem_r_addr)
//  count        out  ADDR_WIDTH+1  words stored, 0..2**ADDR_WIDTH
//  full         out  1             count == 2**ADDR_WIDTH
//  empty        out  1             count == 0
//  almost_full  out  1             count >= AFULL_THR
// BEHAVIOUR
//  - Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; MSB is wrap bit. empty: ptrs equal;
//    full: low bits equal, MSBs differ. count = wr_ptr - rd_ptr (modulo 2**(ADDR_WIDTH+1)).
//  - Reset/flush: wr_ptr=rd_ptr=0, last_grant=1 (so s0 wins first tie); outputs then
//    empty=1, full=0, almost_full=0, count=0, m_valid=0, s*_ready=0. Memory not cleared.
//    flush takes effect like rst; a write or pop in the flush cycle is discarded, no ready.
//  - Arbitration (combinational from registered state): if full, no grant. Else only one
//    valid -> grant it; both valid -> grant the one != last_grant. last_grant updates on grant.
//  - Grant cycle: sX_ready=1, mem_wclk_en=1, mem_w_addr=wr_ptr[ADDR_WIDTH-1:0],
//    mem_w_data=sX_data; wr_ptr++ at clock edge. mem_w_data=0 when no grant.
//  - Read: mem_r_addr=rd_ptr[ADDR_WIDTH-1:0]; m_data=mem_r_data; pop -> rd_ptr++.
//    Write-to-m_valid latency 1 cycle (no empty bypass).
//  - Simultaneous grant+pop: both pointers advance, count unchanged. When full, pop in same
//    cycle does not enable a write (ready uses registered full; no pass-through).
//  - Pointer wrap: 2**(ADDR_WIDTH+1) rolls to 0 naturally; addresses wrap at depth.
//  - Flags and count are derived from registered pointers (glitch-free, same cycle).
//  - ready never depends on m_ready; s*_ready may depend on s*_valid (valid->ready path).
//  - Assertions: no grant while full; no pop while empty; s*_ready one-hot or zero.
// STRUCTURE
//  - Package fifo_ctrl_pkg: typedef ptr_t (ADDR_WIDTH+1 bits), enum src_e {SRC0,SRC1}.
//  - Sub-module rr_arb2 (req[1:0], last_grant in, gnt[1:0] out, combinational) instantiated
//    once; pointer/flag logic in this module. Memory is instantiated by the parent.
// TESTING (ADDR_WIDTH=4, AFULL_THR=12, bench models memory)
//  1 Reset: rst=1 2 cycles with s0/s1 valid -> empty=1,count=0,s*_ready=0,mem_wclk_en=0.
//  2 s0 only writes 0x11..0x20 (16 words) -> full=1 after 16th, almost_full at count 12,
//    17th word s0_ready=0; then pop 16 -> m_data 0x11..0x20 in order, empty=1.
//  3 s0,s1 both always valid, data 0xA0+n / 0xB0+n -> writes alternate A0,B0,A1,B1...; first=A0.
//  4 Full FIFO, m_ready=1 and s1_valid=1 same cycle -> pop only, count 16->15; next cycle
//    s1 granted, count back to 16.
//  5 Steady stream 40 words with m_ready=1 -> pointers wrap twice, order preserved, count<=1.
//  6 count=7, assert flush with s0_valid&m_ready -> next cycle count=0, empty=1, word dropped.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the two-producer FIFO write-arbitration controller.
package fifo_ctrl_pkg;

  // Default address width of the FIFO memory; depth = 2**FIFO_ADDR_WIDTH.
  localparam int unsigned FIFO_ADDR_WIDTH = 4;

  // Pointer carries one extra wrap bit above the memory address.
  typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

  // Producer identity, used to remember who was granted last.
  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
// On a tie the requester that was not granted last wins.
module rr_arb2
  import fifo_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  src_e       last_grant,
  output logic [1:0] gnt
);

  // Grant the sole requester, or alternate on a tie.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == SRC1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// FIFO controller sharing one memory write port between two producers (round-robin)
// and sequencing it with wrap-bit pointers. The memory itself lives in the parent.
module fifo_wr_arb_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AFULL_THR  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s0_valid,
  input  logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  mem_wclk_en,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);

  localparam logic [ADDR_WIDTH:0] AfullLvl = AFULL_THR[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  src_e                last_grant_q, last_grant_d;
  logic [1:0]          req, gnt;
  logic                clr, wr_en, rd_en;

  // Reset and flush share one clearing path; both suppress any transfer that cycle.
  assign clr = rst | flush;

  // Flags come straight from registered pointers, so they never glitch.
  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                       (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign almost_full = (count >= AfullLvl);

  // Registered full gates requests: a same-cycle pop never frees a slot for a write.
  assign req = {s1_valid, s0_valid} & {2{~full & ~clr}};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign s0_ready    = gnt[0];
  assign s1_ready    = gnt[1];
  assign wr_en       = |gnt;
  assign mem_wclk_en = wr_en;
  assign mem_w_addr  = wr_ptr_q[ADDR_WIDTH-1:0];

  assign m_valid    = ~empty;
  assign m_data     = mem_r_data;
  assign mem_r_addr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_en      = ~empty & m_ready & ~clr;

  // Write data mux: granted producer's word, zero when idle.
  always_comb begin
    mem_w_data = '0;
    if (gnt[1]) begin
      mem_w_data = s1_data;
    end else if (gnt[0]) begin
      mem_w_data = s0_data;
    end
  end

  // Next-state for pointers and round-robin history.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    last_grant_d = last_grant_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (gnt[0]) begin
      last_grant_d = SRC0;
    end else if (gnt[1]) begin
      last_grant_d = SRC1;
    end
  end

  // State register; clearing leaves last_grant at SRC1 so producer 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_grant_q <= SRC1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifndef SYNTHESIS
  a_no_grant_full: assert property (@(posedge clk) disable iff (rst) !(full && wr_en));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (rst) !(empty && rd_en));
  a_ready_onehot:  assert property (@(posedge clk) disable iff (rst)
                                    $onehot0({s1_ready, s0_ready}));
`endif

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Self-checking bench for fifo_wr_arb_ctrl with a behavioural memory and a scoreboard.
module tb_fifo_wr_arb_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int DEPTH = 16;
  localparam int THR   = 12;

  logic       clk = 1'b0;
  logic       rst, flush, s0_valid, s1_valid, m_ready;
  logic [7:0] s0_data, s1_data, m_data, mem_w_data, mem_r_data;
  logic       s0_ready, s1_ready, m_valid, mem_wclk_en, full, empty, almost_full;
  logic [3:0] mem_w_addr, mem_r_addr;
  logic [4:0] count;

  logic [7:0] mem [DEPTH];

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb[$];
  int         mcount = 0;
  logic       mlast = 1'b1;
  ptr_t       mwptr = '0;
  ptr_t       mrptr = '0;
  bit         known = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wclk_en) mem[mem_w_addr] <= mem_w_data;
  assign mem_r_data = mem[mem_r_addr];

  fifo_wr_arb_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .AFULL_THR  (THR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .s0_valid    (s0_valid),
    .s0_data     (s0_data),
    .s0_ready    (s0_ready),
    .s1_valid    (s1_valid),
    .s1_data     (s1_data),
    .s1_ready    (s1_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .mem_wclk_en (mem_wclk_en),
    .mem_w_addr  (mem_w_addr),
    .mem_w_data  (mem_w_data),
    .mem_r_addr  (mem_r_addr),
    .mem_r_data  (mem_r_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  // One clock of stimulus: predict grant/pop from the model, compare, then advance the model.
  task automatic cycle(input logic r, input logic fl, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic mr, output int g);
    logic e0, e1, pop;
    rst = r; flush = fl; s0_valid = v0; s0_data = d0; s1_valid = v1; s1_data = d1;
    m_ready = mr;
    #1;
    g = -1;
    if (!(r || fl) && known && mcount < DEPTH) begin
      if (v0 && v1) g = mlast ? 0 : 1;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    e0 = (g == 0);
    e1 = (g == 1);
    total++;
    if ({s1_ready, s0_ready} !== {e1, e0}) begin
      bad++;
      $display("FAIL ready: got s1/s0=%b%b want %b%b", s1_ready, s0_ready, e1, e0);
    end
    total++;
    if (mem_wclk_en !== (g >= 0)) begin
      bad++;
      $display("FAIL wclk_en: got %b want %b", mem_wclk_en, (g >= 0));
    end
    if (g >= 0) begin
      total++;
      if (mem_w_addr !== mwptr[3:0] || mem_w_data !== (g == 1 ? d1 : d0)) begin
        bad++;
        $display("FAIL write port: got addr=%0d data=%h want addr=%0d data=%h",
                 mem_w_addr, mem_w_data, mwptr[3:0], (g == 1 ? d1 : d0));
      end
    end
    if (known) begin
      total++;
      if (count !== mcount[4:0]) begin
        bad++;
        $display("FAIL count: got %0d want %0d", count, mcount);
      end
      total++;
      if ({full, empty, almost_full, m_valid} !==
          {mcount == DEPTH, mcount == 0, mcount >= THR, mcount != 0}) begin
        bad++;
        $display("FAIL flags(full,empty,afull,mvalid): got %b%b%b%b want %b%b%b%b",
                 full, empty, almost_full, m_valid,
                 mcount == DEPTH, mcount == 0, mcount >= THR, mcount != 0);
      end
      total++;
      if (mem_r_addr !== mrptr[3:0]) begin
        bad++;
        $display("FAIL r_addr: got %0d want %0d", mem_r_addr, mrptr[3:0]);
      end
    end
    pop = known && !(r || fl) && mr && (mcount > 0);
    if (pop) begin
      total++;
      if (m_data !== sb[0]) begin
        bad++;
        $display("FAIL pop data: got %h want %h", m_data, sb[0]);
      end
    end
    @(posedge clk);
    if (r || fl) begin
      mcount = 0; sb.delete(); mlast = 1'b1; mwptr = '0; mrptr = '0; known = 1'b1;
    end else begin
      if (pop) begin
        void'(sb.pop_front()); mcount--; mrptr++;
      end
      if (g >= 0) begin
        sb.push_back(g == 1 ? d1 : d0); mcount++; mwptr++; mlast = g[0];
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int g;
    cycle(1, 0, 1, 8'h01, 1, 8'h02, 0, g);
    cycle(1, 0, 1, 8'h01, 1, 8'h02, 0, g);
    total++;
    if ({empty, count, s0_ready, s1_ready, mem_wclk_en} !== {1'b1, 5'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset state: got empty=%b count=%0d rdy=%b%b wen=%b want 1 0 00 0",
               empty, count, s0_ready, s1_ready, mem_wclk_en);
    end
  endtask

  task automatic test_fill_drain();
    int g;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, 8'(8'h11 + i), 0, 8'h00, 0, g);
      total++;
      if (almost_full !== (i + 1 >= THR)) begin
        bad++;
        $display("FAIL almost_full at count %0d: got %b want %b", i + 1, almost_full,
                 (i + 1 >= THR));
      end
    end
    total++;
    if (full !== 1'b1 || count !== 5'd16) begin
      bad++;
      $display("FAIL fill: got full=%b count=%0d want 1 16", full, count);
    end
    cycle(0, 0, 1, 8'h21, 0, 8'h00, 0, g);
    total++;
    if (s0_ready !== 1'b0) begin
      bad++;
      $display("FAIL 17th word: got s0_ready=%b want 0", s0_ready);
    end
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 8'h00, 0, 8'h00, 1, g);
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL drain: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_alternate();
    int g;
    int n0 = 0;
    int n1 = 0;
    cycle(0, 1, 0, 8'h00, 0, 8'h00, 0, g);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 8'(8'hA0 + n0), 1, 8'(8'hB0 + n1), 0, g);
      if (g == 0) n0++;
      else if (g == 1) n1++;
      if (i == 0) begin
        total++;
        if (m_data !== 8'hA0) begin
          bad++;
          $display("FAIL first tie winner: got head=%h want a0", m_data);
        end
      end
    end
    total++;
    if (count !== 5'd8) begin
      bad++;
      $display("FAIL alternate count: got %0d want 8", count);
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 8'h00, 0, 8'h00, 1, g);
  endtask

  task automatic test_full_pop();
    int g;
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 8'(8'h30 + i), 0, 8'h00, 0, g);
    cycle(0, 0, 0, 8'h00, 1, 8'hC1, 1, g);
    total++;
    if (count !== 5'd15) begin
      bad++;
      $display("FAIL full+pop: got count=%0d want 15", count);
    end
    cycle(0, 0, 0, 8'h00, 1, 8'hC1, 0, g);
    total++;
    if (count !== 5'd16 || full !== 1'b1) begin
      bad++;
      $display("FAIL refill: got count=%0d full=%b want 16 1", count, full);
    end
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 8'h00, 0, 8'h00, 1, g);
  endtask

  task automatic test_stream();
    int g;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 1, 8'(8'h40 + i), 0, 8'h00, 1, g);
      total++;
      if (count > 5'd1) begin
        bad++;
        $display("FAIL stream count at %0d: got %0d want <=1", i, count);
      end
    end
    cycle(0, 0, 0, 8'h00, 0, 8'h00, 1, g);
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL stream drain: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_flush();
    int g;
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 8'(8'h70 + i), 0, 8'h00, 0, g);
    total++;
    if (count !== 5'd7) begin
      bad++;
      $display("FAIL pre-flush count: got %0d want 7", count);
    end
    cycle(0, 1, 1, 8'h99, 0, 8'h00, 1, g);
    total++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL flush: got count=%0d empty=%b want 0 1", count, empty);
    end
    cycle(0, 0, 1, 8'h55, 0, 8'h00, 0, g);
    cycle(0, 0, 0, 8'h00, 0, 8'h00, 1, g);
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL post-flush: got empty=%b want 1", empty);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0;
    s0_data = 8'h00; s1_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_alternate();
    test_full_pop();
    test_stream();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
